// File: rtl/power_pkg.sv
// Shared constants and types for the power window logger slice.
package power_pkg;

  localparam int         FRAME_LEN      = 5;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic logic [7:0] frame_chk(input logic [7:0] avg,
                                           input logic [7:0] max_val,
                                           input logic [7:0] min_val);
    return avg ^ max_val ^ min_val;
  endfunction

endpackage

// File: rtl/window_stats.sv
// Running sum/max/min over a window of 2^WINDOW_LOG2 valid samples.
// Report outputs include the sample taken on the completing edge.
module window_stats #(
  parameter int WINDOW_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       done,
  output logic [7:0] avg,
  output logic [7:0] max_val,
  output logic [7:0] min_val
);

  localparam int SW = WINDOW_LOG2 + 8;

  logic [SW-1:0]          sum_q, sum_d, sum_inc;
  logic [7:0]             max_q, max_d, max_inc;
  logic [7:0]             min_q, min_d, min_inc;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      max_q <= 8'h00;
      min_q <= 8'hFF;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      max_q <= max_d;
      min_q <= min_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    sum_inc = sum_q + {{WINDOW_LOG2{1'b0}}, sample_in};
    max_inc = (sample_in > max_q) ? sample_in : max_q;
    min_inc = (sample_in < min_q) ? sample_in : min_q;
    done    = sample_valid && (cnt_q == {WINDOW_LOG2{1'b1}});
    sum_d   = sum_q;
    max_d   = max_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
    // The completing sample is folded into the report, then the window restarts.
    if (done) begin
      sum_d = '0;
      max_d = 8'h00;
      min_d = 8'hFF;
      cnt_d = '0;
    end else if (sample_valid) begin
      sum_d = sum_inc;
      max_d = max_inc;
      min_d = min_inc;
      cnt_d = cnt_q + WINDOW_LOG2'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign avg     = sum_inc[SW-1:WINDOW_LOG2];
  assign max_val = max_inc;
  assign min_val = min_inc;

endmodule

// File: rtl/power_window_logger.sv
// Window statistics logger: turns each finished window into a 5-byte frame
// streamed out over valid/ready; reports arriving mid-frame are dropped.
module power_window_logger
  import power_pkg::*;
#(
  parameter int         WINDOW_LOG2 = 4,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  state_e                    state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic [FRAME_LEN-1:0][7:0] frame_q, frame_d, new_frame;
  logic                      overrun_q, overrun_d;
  logic [7:0]                out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      win_done, hs, last_hs;
  logic [7:0]                w_avg, w_max, w_min;

  window_stats #(.WINDOW_LOG2(WINDOW_LOG2)) u_stats (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .done         (win_done),
    .avg          (w_avg),
    .max_val      (w_max),
    .min_val      (w_min)
  );

  assign new_frame = {frame_chk(w_avg, w_max, w_min), w_min, w_max, w_avg, HEADER};
  assign hs        = out_valid_q && out_ready;
  assign last_hs   = hs && (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      frame_q     <= '0;
      overrun_q   <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      overrun_q   <= overrun_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (win_done) begin
          state_d = SEND;
          idx_d   = 3'd0;
          frame_d = new_frame;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        // A report landing on the final handshake chains straight into a new frame.
        if (last_hs) begin
          idx_d = 3'd0;
          if (win_done) begin
            state_d = SEND;
            frame_d = new_frame;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (hs) begin
            idx_d = idx_q + 3'd1;
          end else begin
            idx_d = idx_q;
          end
          if (win_done) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    out_valid_d = (state_d == SEND);
    if (state_d == SEND) begin
      out_data_d = frame_d[idx_d];
    end else begin
      out_data_d = out_data_q;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/power_window_logger.md
# power_window_logger

Downstream consumer of the converter's 8-bit scaled power output. The block collects valid power samples over a fixed window of 2^WINDOW_LOG2 samples and computes the window average, peak and minimum. Each finished window becomes a 5-byte report frame. Frames leave the block as a byte stream with a valid/ready handshake, ready for the telemetry/data path of the top module.

## Interface
Parameters:
- WINDOW_LOG2, default 4: window length is 2^WINDOW_LOG2 samples; legal range 1..8.
- HEADER, default 8'hA5: first byte of every frame.

Ports:
- clk  in  1  system clock; all state is clocked on the rising edge.
- rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- sample_in  in  8  converted power sample from the converter stage (unsigned).
- sample_valid  in  1  sample_in is taken on every clk edge where this is high.
- out_data  out  8  current frame byte.
- out_valid  out  1  out_data holds a valid byte.
- out_ready  in  1  consumer accepts out_data on a clk edge where out_valid && out_ready.
- overrun  out  1  sticky flag: at least one window report was dropped.

## Operation
- Accumulator state:
  - sum: WINDOW_LOG2+8 bits, cannot overflow.
  - max: 8 bits, reset 8'h00.
  - min: 8 bits, reset 8'hFF.
  - cnt: WINDOW_LOG2 bits, reset 0.
- Each valid sample updates sum, max and min, then increments cnt; cnt wraps to 0 after 2^WINDOW_LOG2 − 1.
- The window completes on the valid sample taken while cnt is all-ones. On that edge:
  - the report is computed using that sample included;
  - sum, max, min and cnt reload to their reset values for the next window.
- Report fields:
  - avg = sum >> WINDOW_LOG2 (truncating).
  - Frame = HEADER, avg, max, min, chk, where chk = avg ^ max ^ min.
- Output FSM states:
  - IDLE: out_valid=0. On window complete, load the frame buffer and go to SEND with byte index 0.
  - SEND: out_valid=1 and out_data=frame[idx]. On each handshake idx increments. A handshake on idx 4 returns to IDLE.
- Accumulation never stalls. Samples keep arriving and are processed in both states.
- Window completes while in SEND:
  - The new report is dropped and overrun is set.
  - Exception: if the same edge is the final handshake (idx 4 accepted), the new frame is loaded and the FSM stays in SEND at idx 0. overrun is not set.
- overrun is cleared only by rst.
- out_data and out_valid are registered, with no combinational path from inputs.
- out_valid must not drop and out_data must not change while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, out_data=8'h00, overrun=0, FSM=IDLE, idx=0, plus accumulator values as listed above.
- Latency: window completes at edge N; out_valid=1 with HEADER is visible after edge N. The header can be accepted at edge N+1 at the earliest.
- Throughput: with out_ready held high, one byte per cycle, so a frame takes 5 cycles.
- Reset mid-frame or mid-window: everything returns to reset values immediately and asynchronously. The partial window and the pending frame are discarded.
- sample_valid=0 cycles do not count toward the window.

## Structure
- Shared package (power_pkg): FRAME_LEN=5, default HEADER constant, and an FSM state enum {IDLE, SEND}.
- One sub-module: window_stats, which holds sum/min/max/cnt and outputs done plus avg/max/min. The frame buffer, FSM, handshake and overrun logic stay in the top of this block.

## Test plan
- Constant input: WINDOW_LOG2=4, 16 valid samples of 8'd50 (0x32), out_ready=1 → bytes A5, 32, 32, 32, 32 on consecutive cycles; overrun=0.
- Ramp with gaps: samples 0..15 with sample_valid low every other cycle → A5, 07, 0F, 00, 08. The header appears the cycle after the 16th valid sample.
- Backpressure: same as the ramp case, but out_ready toggles 1,0,0,1,... → out_data/out_valid are held stable while stalled, and all 5 bytes arrive in order with none lost or duplicated.
- Overrun: out_ready=0 while 32 valid samples of 8'd10 are sent → first frame held at A5; overrun=1 after the 32nd sample. Releasing out_ready then yields only the first frame (A5, 0A, 0A, 0A, 0A).
- Back-to-back boundary: the 16th sample of window 2 lands on the same edge as the chk handshake of frame 1 → frame 2 starts the next cycle; overrun stays 0.
- Reset mid-frame: assert rst after byte 2 is accepted → out_valid=0 and overrun=0 immediately. A fresh 16-sample window then produces a correct full frame starting with A5.
